// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared types and constants for the 4-to-1 round-robin collector
//
// Purpose : channel count, select width, select type and FSM state encoding
//           shared by mux_4x1_rr and rr_arb_4.
// Ports   : none (package).
package mux_pkg;

  localparam int CH    = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb_4.sv
// rtl/rr_arb_4.sv - combinational 4-way arbiter, round-robin or fixed priority
//
// Purpose : grants the first requesting channel found when scanning upward
//           from i_ptr (wrapping 3 -> 0). With MUX_4X1_FIXED_PRIO_EN defined
//           the pointer input is removed and the scan always starts at 0,
//           so the lowest index wins.
// Ports   : i_req     [3:0] per-channel request
//           i_ptr     [1:0] scan start index (absent in fixed-priority build)
//           o_gnt     [3:0] one-hot grant, zero when no request
//           o_gnt_idx [1:0] encoded grant index, 0 when no request
module rr_arb_4
  import mux_pkg::*;
(
  input  logic [CH-1:0] i_req,
`ifndef MUX_4X1_FIXED_PRIO_EN
  input  sel_t          i_ptr,
`endif
  output logic [CH-1:0] o_gnt,
  output sel_t          o_gnt_idx
);

  logic w_found;
  sel_t w_idx;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < CH; k++) begin
`ifndef MUX_4X1_FIXED_PRIO_EN
      // 2-bit addition wraps naturally, giving the 3 -> 0 rotation
      w_idx = i_ptr + sel_t'(k);
`else
      w_idx = sel_t'(k);
`endif
      if (!w_found && i_req[w_idx]) begin
        w_found          = 1'b1;
        o_gnt[w_idx]     = 1'b1;
        o_gnt_idx        = w_idx;
      end
    end
  end

endmodule

// File: rtl/mux_4x1_rr.sv
// rtl/mux_4x1_rr.sv - 4-to-1 valid/ready collector with round-robin arbitration
//
// Purpose : merges four valid/ready input channels into one registered output
//           stream tagged with the source channel index. Build option
//           MUX_4X1_FIXED_PRIO_EN replaces round-robin with fixed priority
//           (channel 0 highest) and removes the rotation pointer.
// Ports   : i_clk                 clock, rising edge
//           i_rst                 asynchronous active-high reset
//           i_in_valid  [3:0]     per-channel valid
//           i_in_data   [4*W-1:0] channel i at [i*WIDTH +: WIDTH]
//           o_in_ready  [3:0]     per-channel ready, one-hot or zero
//           o_out_valid           output register holds a beat
//           o_out_data  [W-1:0]   data of the granted beat
//           o_out_sel   [1:0]     channel index of the beat
//           i_out_ready           downstream accepts the beat
module mux_4x1_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [CH-1:0]       i_in_valid,
  input  logic [CH*WIDTH-1:0] i_in_data,
  output logic [CH-1:0]       o_in_ready,
  output logic                o_out_valid,
  output logic [WIDTH-1:0]    o_out_data,
  output sel_t                o_out_sel,
  input  logic                i_out_ready
);

  state_t           r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  sel_t             r_out_sel;
  logic             w_load;
  logic             w_xfer;
  logic [CH-1:0]    w_gnt;
  sel_t             w_gnt_idx;

`ifndef MUX_4X1_FIXED_PRIO_EN
  sel_t r_ptr;

  rr_arb_4 u_arb (
    .i_req     (i_in_valid),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );
`else
  rr_arb_4 u_arb (
    .i_req     (i_in_valid),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );
`endif

  // Output register is free, or is being drained this cycle
  assign w_load     = !r_out_valid || i_out_ready;
  // Reset is asynchronous, so ready must drop combinationally with it
  assign o_in_ready = i_rst ? '0 : (w_gnt & {CH{w_load}});
  assign w_xfer     = |(i_in_valid & o_in_ready);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
`ifndef MUX_4X1_FIXED_PRIO_EN
      r_ptr       <= '0;
`endif
    end else begin
      if (w_xfer) begin
        r_out_data <= i_in_data[w_gnt_idx*WIDTH +: WIDTH];
        r_out_sel  <= w_gnt_idx;
`ifndef MUX_4X1_FIXED_PRIO_EN
        r_ptr      <= w_gnt_idx + sel_t'(1);
`endif
      end
      case (r_state)
        EMPTY: begin
          if (w_xfer) begin
            r_state     <= FULL;
            r_out_valid <= 1'b1;
          end
        end
        FULL: begin
          // Drained with nothing new: data/sel keep their last value
          if (i_out_ready && !w_xfer) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux_4x1_rr.sv
// tb/tb_mux_4x1_rr.sv - self-checking bench for mux_4x1_rr
module tb_mux_4x1_rr;

  localparam int W = 8;
`ifdef MUX_4X1_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  always #5 clk = ~clk;

  mux_4x1_rr #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .o_out_data  (out_data),
    .o_out_sel   (out_sel),
    .i_out_ready (out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pointer, output beat held downstream
  int       m_ptr;
  bit       m_valid;
  int       m_data;
  int       m_sel;
  logic [W-1:0] chd [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input bit ordy);
    in_valid  = v;
    out_ready = ordy;
    in_data   = {chd[3], chd[2], chd[1], chd[0]};
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_data  = 0;
    m_sel   = 0;
  endtask

  // First valid channel scanning upward from the pointer, -1 if none
  function automatic int model_grant();
    int c;
    for (int k = 0; k < 4; k++) begin
      c = FIXED ? k : (m_ptr + k) % 4;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic step();
    int g;
    bit ld;
    logic [3:0] er;
    g  = model_grant();
    ld = !m_valid || out_ready;
    er = (ld && g >= 0) ? 4'(1 << g) : 4'b0000;
    #1;
    chk("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    if (er != 4'b0000) begin
      m_data  = int'(chd[g]);
      m_sel   = g;
      m_valid = 1'b1;
      m_ptr   = (g + 1) % 4;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_sel", 32'(out_sel), 32'(m_sel));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) chd[i] = '0;
    rst = 1'b1;
    drive(4'b1111, 1'b1);
    model_reset();

    // Reset state, ready held low while reset is asserted
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    drive(4'b0000, 1'b1);
    rst = 1'b0;
    #4;

    // All four valid, no bubbles, rotation 0,1,2,3,0
    chd[0] = 8'h10; chd[1] = 8'h11; chd[2] = 8'h12; chd[3] = 8'h13;
    drive(4'b1111, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_valid", 32'(out_valid), 32'd1);
      chk("rr_sel", 32'(out_sel), FIXED ? 32'd0 : 32'(k % 4));
      chk("rr_data", 32'(out_data), FIXED ? 32'h10 : 32'(8'h10 + k % 4));
    end

    // Drain, then backpressure on a beat from ch1
    drive(4'b0000, 1'b1);
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chd[1] = 8'h3C;
    drive(4'b0010, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h3C);
      chk("bp_sel", 32'(out_sel), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    chd[1] = 8'h3D;
    drive(4'b0010, 1'b1);
    #1;
    chk("release_in_ready", 32'(in_ready), 32'b0010);
    step();
    chk("release_data", 32'(out_data), 32'h3D);

    // Single channel 3 on consecutive cycles
    for (int k = 0; k < 3; k++) begin
      chd[3] = 8'(8'hF0 + k);
      drive(4'b1000, 1'b1);
      step();
      chk("single_sel", 32'(out_sel), 32'd3);
      chk("single_data", 32'(out_data), 32'(8'hF0 + k));
    end

    // Wrap: after ch3, ch0 goes before ch3
    chd[0] = 8'hA0; chd[3] = 8'hA3;
    drive(4'b1001, 1'b1);
    step();
    chk("wrap_first", 32'(out_sel), 32'd0);
    step();
    chk("wrap_second", 32'(out_sel), FIXED ? 32'd0 : 32'd3);

    // Idle drain: one beat then nothing
    chd[0] = 8'h77;
    drive(4'b0001, 1'b1);
    step();
    chk("idle_valid1", 32'(out_valid), 32'd1);
    drive(4'b0000, 1'b1);
    step();
    chk("idle_valid0", 32'(out_valid), 32'd0);
    chk("idle_hold", 32'(out_data), 32'h77);
    step();

    // Randomized traffic against the model
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 4; i++) chd[i] = 8'($urandom_range(0, 255));
      drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      step();
    end

    // Reset while FULL under backpressure
    drive(4'b0000, 1'b1);
    step();
    chd[2] = 8'hA5;
    drive(4'b0100, 1'b0);
    step();
    chk("pre_rst_data", 32'(out_data), 32'hA5);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_data", 32'(out_data), 32'd0);
    chk("async_sel", 32'(out_sel), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd0);
    #3;
    rst = 1'b0;
    model_reset();
    drive(4'b0100, 1'b1);
    step();
    chk("post_rst_sel", 32'(out_sel), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_4x1_rr.md
Name: mux_4x1_rr

Overview:
- Sequential 4-to-1 collector: merges four valid/ready input channels into one output channel, with round-robin arbitration.
- It is the converging counterpart of the 1x4 demux fan-out. A beat routed out on channel N by a demux is brought back onto one stream, tagged with N.
- Sits at the merge point of the datapath. It feeds a single downstream consumer.

Parameters:
- WIDTH, 8, data width of each input channel and of the output.
- CH, 4, number of input channels. Fixed at 4; the select field is 2 bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  4  per-channel valid; bit i belongs to channel i.
- in_data  input  4*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  4  per-channel ready; one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data of the granted beat.
- out_sel  output  2  channel index of the beat in out_data.
- out_ready  input  1  downstream accepts the beat this cycle.

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0, FSM=EMPTY.
  - A beat held in the output register is dropped.
  - in_ready goes to 0 while rst=1.
- load = !out_valid | out_ready. This is the output register's free-or-draining condition.
- Grant (combinational):
  - Scan in_valid starting at index ptr, ascending, wrapping 3 -> 0.
  - The first set bit is granted (one-hot grant[3:0]).
  - grant=0 if in_valid=0.
- in_ready = grant & {4{load}}.
  - in_ready never depends on in_valid of a non-granted channel.
  - At most one bit is set.
- Transfer on channel i: in_valid[i] & in_ready[i] at the clock edge.
  - out_data <= channel i data.
  - out_sel <= i.
  - out_valid <= 1.
  - ptr <= (i+1) mod 4.
- Latency: 1 cycle, input handshake to out_valid.
- Throughput: 1 beat/cycle while out_ready=1.
- FSM states:
  - EMPTY (out_valid=0): go to FULL on any transfer.
  - FULL (out_valid=1):
    - out_ready=1 with a new transfer: stay FULL, register reloads.
    - out_ready=1 with no transfer: go to EMPTY; out_data/out_sel keep their last value.
    - out_ready=0: stay FULL; out_data/out_sel are held stable and in_ready=0.
- Boundary conditions:
  - All four valid, out_ready held 1: grant order is 0,1,2,3,0,...
  - Single channel valid: granted every cycle regardless of ptr.
  - Pointer wrap: after granting 3, ptr=0.
  - Simultaneous drain and load: accepted in the same cycle with no bubble.
  - in_valid deasserted before a handshake: no transfer and no ptr change.
  - ptr changes only on a transfer.

Optional Feature:
- Macro: MUX_4X1_FIXED_PRIO_EN.
- Defined: ptr is removed. Grant is fixed priority, lowest index wins (channel 0 highest). All other behaviour is unchanged.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package mux_pkg:
  - localparam CH=4.
  - localparam SEL_W=2.
  - typedef sel_t (logic [1:0]).
  - FSM enum state_t {EMPTY, FULL}.
- Sub-module rr_arb_4:
  - Inputs: req[3:0], ptr[1:0].
  - Output: one-hot gnt[3:0], plus encoded gnt_idx.
  - Purely combinational, with the fixed-priority variant selected by the macro.
- Top level holds the output register, ptr and the FSM.

Test Plan:
- Reset mid-FULL: load data 0xA5 on ch2, hold out_ready=0, assert rst → out_valid=0, out_data=0x00, out_sel=0, in_ready=0000 immediately, without waiting for a clock edge.
- All four valid with data 0x10,0x11,0x12,0x13, out_ready=1 → outputs 0x10/0, 0x11/1, 0x12/2, 0x13/3, then 0x10/0, with no bubbles. With MUX_4X1_FIXED_PRIO_EN the output is 0x10/0 on every cycle.
- Backpressure: ch1 valid with 0x3C, out_ready=0 for 3 cycles → out_valid=1, out_data=0x3C, out_sel=1 stable across all 3 cycles, in_ready=0000. Release → next beat accepted the same cycle.
- Single channel: only ch3 valid, with 0xF0,0xF1,0xF2 → all three output with out_sel=3 on consecutive cycles, ptr=0 after each.
- Wrap/fairness: grant ch3, then ch0 and ch3 both valid → ch0 granted first, then ch3.
- Idle drain: one beat on ch0, then in_valid=0 → out_valid is 1 for exactly 1 cycle, then 0 (EMPTY). out_data retains its last value.
